// File: rtl/int_seq_if.sv
// Core-side bundle for the trap/interrupt sequencer: trap events, pipeline context,
// CSR snapshot in; stall, CSR write port and fetch redirect out.
interface int_seq_if #(parameter int XLEN = 32);
    logic            ecall_i;
    logic            ebreak_i;
    logic            mret_i;
    logic            ext_irq_i;
    logic            tmr_irq_i;
    logic [XLEN-1:0] inst_addr_i;
    logic            ex_branch_i;
    logic [XLEN-1:0] ex_target_i;
    logic            mem_busy_i;
    logic [XLEN-1:0] mstatus_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            stallreq_o;
    logic            csr_we_o;
    logic [11:0]     csr_waddr_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            int_assert_o;
    logic [XLEN-1:0] int_addr_o;

    modport master (
        output ecall_i, ebreak_i, mret_i, ext_irq_i, tmr_irq_i, inst_addr_i,
               ex_branch_i, ex_target_i, mem_busy_i, mstatus_i, mtvec_i, mepc_i,
        input  stallreq_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
    );

    modport slave (
        input  ecall_i, ebreak_i, mret_i, ext_irq_i, tmr_irq_i, inst_addr_i,
               ex_branch_i, ex_target_i, mem_busy_i, mstatus_i, mtvec_i, mepc_i,
        output stallreq_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
    );
endinterface

// File: rtl/int_seq.sv
// Trap/interrupt sequencer: stalls the core, writes mepc/mcause/mstatus one per cycle,
// then issues a single-cycle fetch redirect to mtvec (trap) or mepc (mret).
module int_seq #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MCAUSE_EXT = 32'h8000000B,
    parameter logic [XLEN-1:0] MCAUSE_TMR = 32'h80000007
) (
    input  logic     clk,
    input  logic     rst,
    int_seq_if.slave bus
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {IDLE, WAIT_MEM, WR_MEPC, WR_MCAUSE, WR_MSTATUS, JUMP} state_t;

    typedef struct packed {
        logic            we;
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
    } csr_wr_t;

    state_t          state;
    csr_wr_t         csr_q;
    logic            int_assert_q;
    logic [XLEN-1:0] int_addr_q;
    logic            mret_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] mepc_q;

    logic            ev;
    logic            ev_mret;
    logic            ev_async;
    logic [XLEN-1:0] ev_cause;
    logic [XLEN-1:0] ev_pc;

    function automatic csr_wr_t csr_wr(input logic [11:0] addr, input logic [XLEN-1:0] data);
        csr_wr_t w;
        w.we   = 1'b1;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Trap stacks MIE into MPIE and disables; mret restores MIE and sets MPIE.
    function automatic csr_wr_t mstatus_wr(input logic is_mret, input logic [XLEN-1:0] mst);
        logic [XLEN-1:0] d;
        d = mst;
        if (is_mret) begin
            d[3] = mst[7];
            d[7] = 1'b1;
        end else begin
            d[7] = mst[3];
            d[3] = 1'b0;
        end
        return csr_wr(A_MSTATUS, d);
    endfunction

    always_comb begin
        ev       = 1'b1;
        ev_mret  = 1'b0;
        ev_async = 1'b0;
        ev_cause = '0;
        if (bus.ecall_i)                          ev_cause = XLEN'(11);
        else if (bus.ebreak_i)                    ev_cause = XLEN'(3);
        else if (bus.mret_i)                      ev_mret  = 1'b1;
        else if (bus.ext_irq_i && bus.mstatus_i[3]) begin
            ev_cause = MCAUSE_EXT;
            ev_async = 1'b1;
        end else if (bus.tmr_irq_i && bus.mstatus_i[3]) begin
            ev_cause = MCAUSE_TMR;
            ev_async = 1'b1;
        end else                                  ev = 1'b0;
    end

    // An IRQ taken under a taken branch must return to the branch target, not the ID PC.
    assign ev_pc = (ev_async && bus.ex_branch_i) ? bus.ex_target_i : bus.inst_addr_i;

    assign bus.stallreq_o   = (state == IDLE) ? ev : (state != JUMP);
    assign bus.csr_we_o     = csr_q.we;
    assign bus.csr_waddr_o  = csr_q.addr;
    assign bus.csr_wdata_o  = csr_q.data;
    assign bus.int_assert_o = int_assert_q;
    assign bus.int_addr_o   = int_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            csr_q        <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
            mret_q       <= 1'b0;
            cause_q      <= '0;
            mepc_q       <= '0;
        end else begin
            csr_q        <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
            case (state)
                IDLE: if (ev) begin
                    mret_q  <= ev_mret;
                    cause_q <= ev_cause;
                    mepc_q  <= ev_pc;
                    if (bus.mem_busy_i) state <= WAIT_MEM;
                    else if (ev_mret) begin
                        state <= WR_MSTATUS;
                        csr_q <= mstatus_wr(1'b1, bus.mstatus_i);
                    end else begin
                        state <= WR_MEPC;
                        csr_q <= csr_wr(A_MEPC, ev_pc);
                    end
                end
                WAIT_MEM: if (!bus.mem_busy_i) begin
                    if (mret_q) begin
                        state <= WR_MSTATUS;
                        csr_q <= mstatus_wr(1'b1, bus.mstatus_i);
                    end else begin
                        state <= WR_MEPC;
                        csr_q <= csr_wr(A_MEPC, mepc_q);
                    end
                end
                WR_MEPC: begin
                    state <= WR_MCAUSE;
                    csr_q <= csr_wr(A_MCAUSE, cause_q);
                end
                WR_MCAUSE: begin
                    state <= WR_MSTATUS;
                    csr_q <= mstatus_wr(mret_q, bus.mstatus_i);
                end
                WR_MSTATUS: begin
                    state        <= JUMP;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= mret_q ? bus.mepc_i : (bus.mtvec_i & ~XLEN'(3));
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_seq.sv
// Randomized + directed bench for int_seq against a transaction-level trap model.
module tb_int_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    int_seq_if #(.XLEN(32)) bus();
    int_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.ecall_i = 0; bus.ebreak_i = 0; bus.mret_i = 0;
        bus.ext_irq_i = 0; bus.tmr_irq_i = 0; bus.mem_busy_i = 0;
    endtask

    // One transaction: event in cycle 0, mem busy for the first `busy` cycles,
    // optional reset during cycle rst_at. Expectations come from the trap rules.
    task automatic run(input logic ec, input logic eb, input logic mr, input logic ext,
                       input logic tmr, input int busy, input logic [31:0] pc,
                       input logic br, input logic [31:0] tgt, input logic [31:0] mst,
                       input logic [31:0] mtv, input logic [31:0] mep, input int rst_at);
        logic        taken, is_mret, async_ev;
        logic [31:0] cause, epc, mst_w, jaddr;
        logic [11:0] ea[$];
        logic [31:0] ed[$];
        logic [11:0] ga[$];
        logic [31:0] gd[$];
        int          gc[$];
        int          stall_n, stall_last, j_n, j_c, n_mst, len;
        logic [31:0] j_a;

        taken = 1; is_mret = 0; async_ev = 0; cause = 0;
        if (ec)                 cause = 11;
        else if (eb)            cause = 3;
        else if (mr)            is_mret = 1;
        else if (ext && mst[3]) begin cause = 32'h8000000B; async_ev = 1; end
        else if (tmr && mst[3]) begin cause = 32'h80000007; async_ev = 1; end
        else                    taken = 0;
        epc = (async_ev && br) ? tgt : pc;
        if (is_mret) mst_w = (mst & ~32'h8) | 32'h80 | (mst[7] ? 32'h8 : 32'h0);
        else         mst_w = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0);
        jaddr = is_mret ? mep : {mtv[31:2], 2'b00};
        if (taken) begin
            if (!is_mret) begin
                ea.push_back(12'h341); ed.push_back(epc);
                ea.push_back(12'h342); ed.push_back(cause);
            end
            ea.push_back(12'h300); ed.push_back(mst_w);
        end

        stall_n = 0; stall_last = -1; j_n = 0; j_c = -1; j_a = 0;
        len = busy + 8;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            bus.ecall_i = (c == 0) && ec;  bus.ebreak_i  = (c == 0) && eb;
            bus.mret_i  = (c == 0) && mr;  bus.ext_irq_i = (c == 0) && ext;
            bus.tmr_irq_i = (c == 0) && tmr;
            bus.mem_busy_i = (c < busy);
            bus.inst_addr_i = pc; bus.ex_branch_i = br; bus.ex_target_i = tgt;
            bus.mstatus_i = mst; bus.mtvec_i = mtv; bus.mepc_i = mep;
            rst = (rst_at >= 0) && (c == rst_at);
            #1;
            if (bus.stallreq_o) begin stall_n++; stall_last = c; end
            if (bus.csr_we_o) begin
                ga.push_back(bus.csr_waddr_o); gd.push_back(bus.csr_wdata_o); gc.push_back(c);
            end
            if (bus.int_assert_o) begin j_n++; j_c = c; j_a = bus.int_addr_o; end
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk("rst_abort_stall", 32'(bus.stallreq_o), 0);
                chk("rst_abort_we", 32'(bus.csr_we_o), 0);
                chk("rst_abort_waddr", 32'(bus.csr_waddr_o), 0);
                chk("rst_abort_wdata", bus.csr_wdata_o, 0);
                chk("rst_abort_assert", 32'(bus.int_assert_o), 0);
                chk("rst_abort_addr", bus.int_addr_o, 0);
            end
        end
        drive_idle();
        rst = 0;

        if (rst_at >= 0) begin
            n_mst = 0;
            foreach (ga[i]) if (ga[i] == 12'h300) n_mst++;
            chk("rst_writes", ga.size(), rst_at);
            chk("rst_no_mstatus", n_mst, 0);
            chk("rst_no_jump", j_n, 0);
        end else begin
            chk("stall_cycles", stall_n, taken ? 1 + busy + ea.size() : 0);
            chk("stall_contig", stall_last, taken ? busy + ea.size() : -1);
            chk("n_writes", ga.size(), ea.size());
            for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
                chk("waddr", 32'(ga[i]), 32'(ea[i]));
                chk("wdata", gd[i], ed[i]);
                chk("wcycle", gc[i], 1 + busy + i);
            end
            chk("n_jumps", j_n, taken ? 1 : 0);
            if (taken) begin
                chk("jump_addr", j_a, jaddr);
                chk("jump_cycle", j_c, 1 + busy + ea.size());
            end
        end
    endtask

    initial begin
        rst = 1;
        drive_idle();
        bus.inst_addr_i = 0; bus.ex_branch_i = 0; bus.ex_target_i = 0;
        bus.mstatus_i = 0; bus.mtvec_i = 0; bus.mepc_i = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", 32'(bus.stallreq_o), 0);
        chk("reset_we", 32'(bus.csr_we_o), 0);
        chk("reset_waddr", 32'(bus.csr_waddr_o), 0);
        chk("reset_wdata", bus.csr_wdata_o, 0);
        chk("reset_assert", 32'(bus.int_assert_o), 0);
        chk("reset_addr", bus.int_addr_o, 0);
        rst = 0;

        //   ec eb mr ex tm busy pc         br tgt        mst        mtvec      mepc       rst
        run(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'h0,   32'h8,  32'h80,  32'h0,   -1);
        run(0, 0, 0, 1, 0, 0, 32'h120, 0, 32'h0,   32'h0,  32'h80,  32'h0,   -1);
        run(0, 0, 0, 1, 0, 0, 32'h120, 0, 32'h0,   32'h8,  32'h80,  32'h0,   -1);
        run(0, 0, 1, 0, 0, 0, 32'h180, 0, 32'h0,   32'h80, 32'h80,  32'h104, -1);
        run(0, 0, 0, 0, 1, 0, 32'h140, 1, 32'h200, 32'h8,  32'h80,  32'h0,   -1);
        run(0, 1, 0, 0, 0, 3, 32'h160, 0, 32'h0,   32'h8,  32'h83,  32'h0,   -1);
        run(1, 0, 0, 0, 0, 0, 32'h100, 0, 32'h0,   32'h8,  32'h80,  32'h0,   2);
        run(1, 0, 0, 1, 0, 0, 32'h1a0, 1, 32'h300, 32'h8,  32'h80,  32'h0,   -1);
        run(0, 0, 1, 0, 0, 2, 32'h1c0, 0, 32'h0,   32'h0,  32'h80,  32'h444, -1);

        for (int t = 0; t < 200; t++) begin
            run($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                $urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3, $urandom,
                $urandom, $urandom & ~32'h3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
